// File: rtl/rgb_pkg.sv
// Shared state encoding and default sizing for the RGB LED PWM fader.
package rgb_pkg;

    localparam int CNT_W_DEFAULT     = 8;
    localparam int FADE_STEP_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        ON       = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    function automatic logic is_fading(state_t s);
        return (s == FADE_IN) || (s == FADE_OUT);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED pin: colour-gated duty compare, registered so the pin drive is glitch-free.
module pwm_channel #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             col,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W:0]   duty,
    output logic             led
);

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= col && ({1'b0, cnt} < duty);
        end
    end

endmodule

// File: rtl/rgb_led_pwm.sv
// RGB LED driver: free-running PWM with a per-period fade in/out sequencer.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | dark, waiting for enable with a non-zero colour
// FADE_IN  | duty ramps up by FADE_STEP per period towards target
// ON       | duty tracks target directly each period
// FADE_OUT | duty ramps down to 0, then reloads colour or goes dark
module rgb_led_pwm
    import rgb_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int FADE_STEP = FADE_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_in,
    input  logic             g_in,
    input  logic             b_in,
    input  logic             en,
    input  logic [CNT_W-1:0] brightness,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             busy
);

    // One spare bit so ramp arithmetic can never wrap.
    localparam logic [CNT_W:0] STEP = (CNT_W+1)'(FADE_STEP);

    logic [CNT_W-1:0] pwm_cnt;
    logic             pb;
    logic [CNT_W:0]   duty, duty_n;
    logic [CNT_W:0]   target, target_n;
    logic [CNT_W:0]   duty_up, duty_down;
    logic [2:0]       col, col_n, col_in;
    state_t           state, state_n;

    assign col_in = {r_in, g_in, b_in};
    assign pb     = &pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            target  <= '0;
            col     <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + CNT_W'(1);
            duty    <= duty_n;
            target  <= target_n;
            col     <= col_n;
            state   <= state_n;
            busy    <= is_fading(state_n);
        end
    end

    always_comb begin
        state_n   = state;
        duty_n    = duty;
        col_n     = col;
        target_n  = target;
        duty_up   = duty + STEP;
        duty_down = (duty > STEP) ? (duty - STEP) : '0;

        if (pb) begin
            target_n = en ? {1'b0, brightness} : '0;
            case (state)
                IDLE: begin
                    duty_n = '0;
                    if (en && (col_in != 3'b000)) begin
                        col_n   = col_in;
                        state_n = FADE_IN;
                    end
                end
                FADE_IN: begin
                    // Abort keeps the current duty so the fade-out starts where we are.
                    if (!en || (col_in != col)) begin
                        state_n = FADE_OUT;
                    end else if (duty_up >= target_n) begin
                        duty_n  = target_n;
                        state_n = ON;
                    end else begin
                        duty_n = duty_up;
                    end
                end
                ON: begin
                    if (!en || (col_in != col)) begin
                        state_n = FADE_OUT;
                    end else begin
                        duty_n = target_n;
                    end
                end
                FADE_OUT: begin
                    duty_n = duty_down;
                    if (duty_down == '0) begin
                        if (en && (col_in != 3'b000)) begin
                            col_n   = col_in;
                            state_n = FADE_IN;
                        end else begin
                            col_n   = 3'b000;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    pwm_channel #(.CNT_W(CNT_W)) u_ch_r (
        .clk  (clk),
        .rst  (rst),
        .col  (col[2]),
        .cnt  (pwm_cnt),
        .duty (duty),
        .led  (led_r)
    );

    pwm_channel #(.CNT_W(CNT_W)) u_ch_g (
        .clk  (clk),
        .rst  (rst),
        .col  (col[1]),
        .cnt  (pwm_cnt),
        .duty (duty),
        .led  (led_g)
    );

    pwm_channel #(.CNT_W(CNT_W)) u_ch_b (
        .clk  (clk),
        .rst  (rst),
        .col  (col[0]),
        .cnt  (pwm_cnt),
        .duty (duty),
        .led  (led_b)
    );

endmodule

// File: doc/rgb_led_pwm.md
RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 Parameter CNT_W, default 8: PWM counter width; PWM period = 2^CNT_W clock cycles.
REQ-002 Parameter FADE_STEP, default 16: duty increment/decrement applied once per PWM period while fading.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 r_in, g_in, b_in  input  1 each  colour select from the upstream RGB_LED comparator stage.
REQ-006 en  input  1  1 = LED drive enabled, 0 = fade to dark.
REQ-007 brightness  input  CNT_W  target duty; 0 = off, 2^CNT_W-1 = max.
REQ-008 led_r, led_g, led_b  output  1 each  registered PWM drive to the physical LED pins.
REQ-009 busy  output  1  high while in FADE_IN or FADE_OUT.

Function
REQ-010 pwm_cnt shall be a free-running CNT_W-bit up-counter that wraps from 2^CNT_W-1 to 0; the wrap cycle is the "period boundary" (pb).
REQ-011 The colour register (col_r/g/b), duty register and target register shall update only at pb; target = en ? brightness : 0, sampled at pb.
REQ-012 led_x shall equal the registered value of col_x AND (pwm_cnt < duty), one clock of latency from pwm_cnt.
REQ-013 duty = 0 shall give a constantly low output; duty = 2^CNT_W-1 shall give low for exactly 1 cycle per period.
REQ-014 FSM states: IDLE, FADE_IN, ON, FADE_OUT; all transitions occur only at pb.
REQ-015 IDLE: duty = 0; if en = 1 and the input colour is non-zero, load the input colour and go to FADE_IN.
REQ-016 FADE_IN: duty = min(duty + FADE_STEP, target); go to ON once duty reaches target; if target = 0, go to ON immediately.
REQ-017 ON: duty = target (brightness changes apply at the next pb, no fade); if en = 0 or the input colour differs from col, go to FADE_OUT.
REQ-018 FADE_OUT: duty = duty - FADE_STEP, saturating at 0; when duty = 0: if en = 1 and the input colour is non-zero, load the new colour and go to FADE_IN, otherwise go to IDLE.
REQ-019 A colour change or en toggle during FADE_IN shall go to FADE_OUT at the next pb, starting from the current duty.
REQ-020 A colour input of 000 while enabled shall be treated as a colour change and shall end in IDLE.
REQ-021 Duty arithmetic shall use CNT_W+1 bits internally; no overflow or underflow wrap.
REQ-022 busy shall be registered and shall be high exactly when state is FADE_IN or FADE_OUT.

Reset
REQ-023 When rst = 1 at a rising edge: pwm_cnt = 0, duty = 0, target = 0, col = 000, state = IDLE, led_r/g/b = 0, busy = 0.
REQ-024 Reset asserted mid-fade shall abort the fade with no residual state; the first pb after release occurs 2^CNT_W cycles later.

Structure
REQ-025 A package rgb_pkg shall hold the state enum (IDLE, FADE_IN, ON, FADE_OUT) and the default CNT_W and FADE_STEP constants.
REQ-026 One sub-module, pwm_channel (compare plus output register, instantiated 3 times), is permitted; the FSM and counter shall stay in the top module.

Verification (CNT_W = 8, FADE_STEP = 16)
REQ-027 Hold rst high 5 cycles -> all outputs 0 and busy 0 throughout; after release, outputs stay 0 while en = 0.
REQ-028 en = 1, brightness = 128, g_in = 1 -> busy rises at the first pb; duty climbs 16, 32, ... 128 over 8 periods; then busy = 0 and led_g is high 128 of 256 cycles per period; led_r and led_b stay 0.
REQ-029 In ON, switch from g_in to r_in -> FADE_OUT over 8 periods down to duty 0, then col = 100 and FADE_IN; led_g and led_r are never high in the same cycle.
REQ-030 brightness = 255 in ON -> led high 255 cycles and low 1 cycle per period; brightness = 0 -> led constantly 0 while state stays ON.
REQ-031 Deassert en at duty 64 mid-FADE_IN -> FADE_OUT over 4 periods, then IDLE, busy = 0.
REQ-032 Assert rst mid-FADE_OUT -> all outputs 0 next cycle; after release with en = 1 and b_in = 1 -> a clean fade-in from duty 16.
